// File: rtl/lcg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcg_pkg: shared constants and FSM state type for the 128-bit LCG.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package lcg_pkg;

  localparam int LCG_W         = 128;
  localparam int LCG_LIMB_W    = 32;
  localparam int LCG_MUL_STEPS = LCG_W / LCG_LIMB_W;

  localparam logic [LCG_W-1:0] LCG_MULTIPLIER = 128'h23F1BC8A9D05E7164459A7C6D83E0912;
  localparam logic [LCG_W-1:0] LCG_INCREMENT  = 128'h7ACED3401B2F980CDD662B9EA4E8D53F;

  typedef enum logic [1:0] {
    ST_ACQ  = 2'd0,
    ST_CALC = 2'd1,
    ST_CMP  = 2'd2,
    ST_FAIL = 2'd3
  } chk_state_e;

endpackage : lcg_pkg
`default_nettype wire

// File: rtl/lcg_serial_mul.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcg_serial_mul: 128x128 -> low-128 multiplier, one 32-bit limb/cycle.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lcg_serial_mul
  import lcg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [LCG_W-1:0] a_i,
  input  logic [LCG_W-1:0] b_i,
  output logic             done_o,
  output logic [LCG_W-1:0] prod_o
);

  localparam int STEP_W = $clog2(LCG_MUL_STEPS);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(LCG_MUL_STEPS - 1);

  logic [LCG_W-1:0]  a_q, a_d;
  logic [LCG_W-1:0]  b_q, b_d;
  logic [LCG_W-1:0]  acc_q, acc_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              busy_q, busy_d;
  logic [LCG_W-1:0]  w_pp;

  // a shifts down a limb per step while b shifts up, so the partial
  // product is already aligned and only low-128 bits are ever kept.
  assign w_pp   = b_q * {{(LCG_W-LCG_LIMB_W){1'b0}}, a_q[LCG_LIMB_W-1:0]};
  assign done_o = busy_q && (step_q == LAST_STEP);
  assign prod_o = acc_q + w_pp;

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    step_d = step_q;
    busy_d = busy_q;
    if (start_i) begin
      a_d    = a_i;
      b_d    = b_i;
      acc_d  = '0;
      step_d = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      a_d    = a_q >> LCG_LIMB_W;
      b_d    = b_q << LCG_LIMB_W;
      acc_d  = acc_q + w_pp;
      step_d = step_q + 1'b1;
      if (done_o) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      step_q <= '0;
      busy_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      step_q <= step_d;
      busy_q <= busy_d;
    end
  end

endmodule : lcg_serial_mul
`default_nettype wire

// File: rtl/lcg_stream_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcg_stream_checker: predicts and checks a 128-bit LCG word stream.   |
// | LCG_CHK_RESYNC_EN: when defined, FAIL reseeds on the next word.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lcg_stream_checker
  import lcg_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int LOCK_THRESH = 4,
  parameter int ERR_THRESH  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [LCG_W-1:0] in_data,
  output logic             in_ready,
  output logic             locked,
  output logic             mismatch,
  output logic             fail,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int RUN_W = $clog2(LOCK_THRESH + 1);
  localparam int ERR_W = $clog2(ERR_THRESH + 1);
  localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_THRESH);
  localparam logic [ERR_W-1:0] ERR_RUN  = ERR_W'(ERR_THRESH);

  chk_state_e       state_q, state_d;
  logic [LCG_W-1:0] pred_q, pred_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [RUN_W-1:0] match_run_q, match_run_d;
  logic [ERR_W-1:0] err_run_q, err_run_d;
  logic             locked_q, locked_d;
  logic             fail_q, fail_d;
  logic             mismatch_q, mismatch_d;

  logic             w_xfer;
  logic             w_mul_start;
  logic             w_mul_done;
  logic [LCG_W-1:0] w_mul_prod;

  assign in_ready  = (state_q != ST_CALC);
  assign w_xfer    = in_valid && in_ready;
  assign locked    = locked_q;
  assign mismatch  = mismatch_q;
  assign fail      = fail_q;
  assign match_cnt = match_cnt_q;
  assign err_cnt   = err_cnt_q;

  // Clear also resets the multiplier so an aborted predict leaves nothing behind.
  lcg_serial_mul u_mul (
    .clk     (clk),
    .rst     (rst || clr),
    .start_i (w_mul_start),
    .a_i     (in_data),
    .b_i     (LCG_MULTIPLIER),
    .done_o  (w_mul_done),
    .prod_o  (w_mul_prod)
  );

  always_comb begin
    state_d     = state_q;
    pred_d      = pred_q;
    match_cnt_d = match_cnt_q;
    err_cnt_d   = err_cnt_q;
    match_run_d = match_run_q;
    err_run_d   = err_run_q;
    locked_d    = locked_q;
    fail_d      = fail_q;
    mismatch_d  = 1'b0;
    w_mul_start = 1'b0;

    unique case (state_q)
      ST_ACQ: begin
        if (w_xfer) begin
          w_mul_start = 1'b1;
          state_d     = ST_CALC;
        end
      end

      ST_CALC: begin
        if (w_mul_done) begin
          pred_d  = w_mul_prod + LCG_INCREMENT;
          state_d = ST_CMP;
        end
      end

      ST_CMP: begin
        if (w_xfer) begin
          if (in_data == pred_q) begin
            if (match_cnt_q != '1) begin
              match_cnt_d = match_cnt_q + 1'b1;
            end
            err_run_d = '0;
            if (match_run_q != LOCK_RUN) begin
              match_run_d = match_run_q + 1'b1;
            end
            locked_d    = (match_run_d == LOCK_RUN);
            w_mul_start = 1'b1;
            state_d     = ST_CALC;
          end else begin
            mismatch_d = 1'b1;
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + 1'b1;
            end
            locked_d    = 1'b0;
            match_run_d = '0;
            err_run_d   = err_run_q + 1'b1;
            if (err_run_d == ERR_RUN) begin
              fail_d  = 1'b1;
              state_d = ST_FAIL;
            end else begin
              // Follow the received stream: the wrong word becomes the new seed.
              w_mul_start = 1'b1;
              state_d     = ST_CALC;
            end
          end
        end
      end

      ST_FAIL: begin
`ifdef LCG_CHK_RESYNC_EN
        if (w_xfer) begin
          fail_d      = 1'b0;
          match_run_d = '0;
          err_run_d   = '0;
          w_mul_start = 1'b1;
          state_d     = ST_CALC;
        end
`else
        fail_d = 1'b1;
`endif
      end

      default: state_d = ST_ACQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q     <= ST_ACQ;
      pred_q      <= '0;
      match_cnt_q <= '0;
      err_cnt_q   <= '0;
      match_run_q <= '0;
      err_run_q   <= '0;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
      mismatch_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pred_q      <= pred_d;
      match_cnt_q <= match_cnt_d;
      err_cnt_q   <= err_cnt_d;
      match_run_q <= match_run_d;
      err_run_q   <= err_run_d;
      locked_q    <= locked_d;
      fail_q      <= fail_d;
      mismatch_q  <= mismatch_d;
    end
  end

endmodule : lcg_stream_checker
`default_nettype wire

// File: tb/tb_lcg_stream_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_lcg_stream_checker: directed scoreboard bench for the checker.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_lcg_stream_checker;

  localparam logic [127:0] MUL = 128'h23F1BC8A9D05E7164459A7C6D83E0912;
  localparam logic [127:0] INC = 128'h7ACED3401B2F980CDD662B9EA4E8D53F;
  localparam logic [127:0] W1  = 128'h9EC08FCAB8357F2321BFD3657D26DE51;

  logic         clk;
  logic         rst;
  logic         clr;
  logic         in_valid;
  logic [127:0] in_data;
  logic         in_ready, locked, mismatch, fail;
  logic [15:0]  match_cnt, err_cnt;
  logic         s_ready, s_locked, s_mismatch, s_fail;
  logic [1:0]   s_match_cnt, s_err_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit mm;
    int m;
    int e;
    bit lk;
    bit fl;
  } exp_t;
  exp_t exp_q[$];

  lcg_stream_checker #(.CNT_W(16), .LOCK_THRESH(4), .ERR_THRESH(2)) u_dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .locked(locked), .mismatch(mismatch), .fail(fail),
    .match_cnt(match_cnt), .err_cnt(err_cnt)
  );

  // Narrow-counter copy fed identically, for saturation.
  lcg_stream_checker #(.CNT_W(2), .LOCK_THRESH(4), .ERR_THRESH(2)) u_sat (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(s_ready), .locked(s_locked), .mismatch(s_mismatch), .fail(s_fail),
    .match_cnt(s_match_cnt), .err_cnt(s_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] nxt(input logic [127:0] x);
    return x * MUL + INC;
  endfunction

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: one cycle after each transfer the registered outputs must match.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      chk("mismatch",      128'(mismatch),    128'(x.mm));
      chk("match_cnt",     128'(match_cnt),   128'(x.m));
      chk("err_cnt",       128'(err_cnt),     128'(x.e));
      chk("locked",        128'(locked),      128'(x.lk));
      chk("fail",          128'(fail),        128'(x.fl));
      chk("sat_match_cnt", 128'(s_match_cnt), 128'(sat3(x.m)));
      chk("sat_err_cnt",   128'(s_err_cnt),   128'(sat3(x.e)));
    end else if (!rst) begin
      chk("mismatch_idle", 128'(mismatch), 128'(0));
    end
  end

  task automatic send(input logic [127:0] w, input bit mm, input int m, input int e,
                      input bit lk, input bit fl, input bit calc);
    int guard;
    int n;
    guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready) begin
      @(negedge clk);
      guard++;
      if (guard > 50) begin
        $display("FAIL in_ready_timeout: got 0 expected 1");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
      end
    end
    @(posedge clk);
    exp_q.push_back('{mm, m, e, lk, fl});
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
    if (calc) begin
      n = 0;
      while (!in_ready && n < 20) begin
        n++;
        @(negedge clk);
      end
      chk("busy_cycles", 128'(n), 128'(4));
    end else begin
      chk("ready_no_calc", 128'(in_ready), 128'(1));
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    logic [127:0] w;
    logic [127:0] bad;
    rst      = 1'b1;
    clr      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",  128'(in_ready),  128'(1));
    chk("rst_locked",    128'(locked),    128'(0));
    chk("rst_fail",      128'(fail),      128'(0));
    chk("rst_match_cnt", 128'(match_cnt), 128'(0));
    chk("rst_err_cnt",   128'(err_cnt),   128'(0));

    // Seed 0: successor is the increment itself.
    send(128'd0, 0, 0, 0, 0, 0, 1);
    send(INC,    0, 1, 0, 0, 0, 1);

    pulse_clr();
    chk("clr_match_cnt", 128'(match_cnt), 128'(0));

    // Seed 1, then lock after four consecutive matches.
    send(128'd1, 0, 0, 0, 0, 0, 1);
    send(W1,     0, 1, 0, 0, 0, 1);
    w = W1;
    for (int k = 2; k <= 4; k++) begin
      w = nxt(w);
      send(w, 0, k, 0, (k == 4), 0, 1);
    end

    // Single error, then tracking resumes from the wrong word.
    bad = nxt(w) ^ 128'h8000_0000_0000_0000_0000_0000_0000_0001;
    send(bad, 1, 4, 1, 0, 0, 1);
    w = nxt(bad);
    send(w, 0, 5, 1, 0, 0, 1);

    // Two consecutive errors force FAIL.
    bad = nxt(w) + 128'd1;
    send(bad, 1, 5, 2, 0, 0, 1);
    bad = nxt(bad) ^ 128'd1;
    send(bad, 1, 5, 3, 0, 1, 0);
`ifdef LCG_CHK_RESYNC_EN
    send(128'd123,      0, 5, 3, 0, 0, 1);
    send(nxt(128'd123), 0, 6, 3, 0, 0, 1);
`else
    send(128'd123,      0, 5, 3, 0, 1, 0);
    send(nxt(128'd123), 0, 5, 3, 0, 1, 0);
`endif

    // Clear in the middle of a predict.
    pulse_clr();
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 128'd5;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
    chk("calc_busy", 128'(in_ready), 128'(0));
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_in_ready",  128'(in_ready),  128'(1));
    chk("clr_locked",    128'(locked),    128'(0));
    chk("clr_fail",      128'(fail),      128'(0));
    chk("clr_err_cnt",   128'(err_cnt),   128'(0));
    chk("clr_match_cnt2", 128'(match_cnt), 128'(0));
    send(128'd0, 0, 0, 0, 0, 0, 1);
    send(INC,    0, 1, 0, 0, 0, 1);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule : tb_lcg_stream_checker
`default_nettype wire

// File: doc/lcg_stream_checker.md
Name: lcg_stream_checker

Overview:
Receive-side checker for the 128-bit LCG random stream. The first accepted word seeds an internal predictor. Each later word is compared against the predicted next value, next = (prev * MULTIPLIER + INCREMENT) mod 2^128. The block reports lock, mismatch and saturating counts, and sits at the consumer end of the PRNG output path for self-test and link integrity checking.

Parameters:
CNT_W, 16, width of match_cnt and err_cnt (saturating)
LOCK_THRESH, 4, consecutive matches required before locked asserts (>=1)
ERR_THRESH, 2, consecutive mismatches that force the FAIL state (>=1)

Ports:
clk  in  1  single clock, all logic on posedge
rst  in  1  synchronous, active-high reset
clr  in  1  synchronous soft clear: same effect as rst
in_valid  in  1  input word valid
in_data  in  128  random word under test
in_ready  out  1  checker can accept a word this cycle
locked  out  1  stream tracked for >= LOCK_THRESH consecutive matches
mismatch  out  1  one-cycle pulse on a compare failure
fail  out  1  sticky; asserted in FAIL state
match_cnt  out  CNT_W  total matched words, saturating
err_cnt  out  CNT_W  total mismatched words, saturating

Behaviour:
- Transfer occurs when in_valid & in_ready are both high in the same cycle. in_data is ignored otherwise.
- Reset and clr: state = ACQ, in_ready=1, locked=0, mismatch=0, fail=0, both counters 0, pred=0, run counters 0. rst/clr take priority over any same-cycle transfer.
- The predictor is a serial multiplier computing a 32x128 partial product per cycle, low 128 bits only. The full predict takes 4 CALC cycles, then INCREMENT is added in the final cycle. All arithmetic wraps mod 2^128.
- States:
  - ACQ: in_ready=1. On transfer: latch the word as the operand and go to CALC. No compare.
  - CALC: in_ready=0 for exactly 4 cycles, accumulating the product. On the 4th cycle pred <= acc + INCREMENT, then go to CMP.
  - CMP: in_ready=1. On transfer: compare in_data with pred.
    - Match: match_cnt++, reset the mismatch run, increment the match run. locked=1 once the run reaches LOCK_THRESH.
    - Mismatch: mismatch pulses the next cycle, err_cnt++, locked=0, match run reset, mismatch run incremented.
    - If the mismatch run reaches ERR_THRESH, go to FAIL. Otherwise latch in_data as the new operand and go to CALC, so the predictor follows the received stream.
  - FAIL: fail=1, in_ready=1, words are consumed and discarded, and counters hold. Leave only via rst/clr, or via the optional feature.
- Throughput: one word per 5 cycles in tracking.
- Latency: mismatch and counter updates are registered, visible the cycle after the compare transfer.
- Counters saturate at all-ones; they never wrap.
- Reset asserted during CALC aborts the computation with no partial result retained.

Optional Feature:
- Macro: LCG_CHK_RESYNC_EN.
- Defined: FAIL is not terminal. The next accepted word in FAIL clears fail and the run counters, is latched as the new seed, and the FSM goes to CALC. err_cnt and match_cnt are preserved.
- Undefined: FAIL is sticky until rst/clr.

Decomposition:
- Shared package lcg_pkg:
  - LCG_MULTIPLIER = 128'h23F1BC8A9D05E7164459A7C6D83E0912
  - LCG_INCREMENT = 128'h7ACED3401B2F980CDD662B9EA4E8D53F
  - LCG_W = 128
  - FSM state enum (ACQ, CALC, CMP, FAIL)
- Sub-module: lcg_serial_mul. 128x128 to low-128 serial multiplier, 4 cycles, with start/done handshake. It is reusable by any future multi-cycle LCG stepper.

Test Plan:
- Seed lock: feed 0, then 0x7ACED3401B2F980CDD662B9EA4E8D53F -> no mismatch, match_cnt=1, in_ready low exactly 4 cycles after each accept.
- Second step: feed 1, then 0x9EC08FCAB8357F2321BFD3657D26DE51 -> match. After LOCK_THRESH=4 consecutive correct words, locked=1.
- Single error: locked stream, inject one wrong word -> mismatch one-cycle pulse, err_cnt=1, locked=0. Tracking continues from the wrong word; the next correct successor of it matches.
- Fail: two consecutive wrong words with ERR_THRESH=2 -> fail=1, in_ready=1, further words leave both counters unchanged. With LCG_CHK_RESYNC_EN, the next word reseeds and fail drops.
- Saturation and clear: CNT_W=2, feed 5 matches -> match_cnt=3 held. Pulse clr mid-CALC -> all outputs at reset values the next cycle, state ACQ.
